pixel_row_sensor: RTL and testbench

- Cycle-level digital model of one row of PIXEL_ARRAY_WIDTH image-sensor pixels with single-slope ADC readout.
- Each pixel does four things:
  - ERASE clears it.
  - EXPOSE integrates a per-pixel light level.
  - CONVERT compares its level against a ramp and latches the shared DIGITAL_RAMP code at the crossing.
  - READ places the latched codes on DATA_OUT.
- The block sits between the sensor control state machine / ramp generator and the row readout register.

---
 rtl/pixel_sensor_pkg.sv | 30 +++
 rtl/pixel_row_sensor_if.sv | 22 ++
 rtl/pixel_cell.sv | 54 +++++
 rtl/pixel_row_sensor.sv | 66 ++++++
 tb/tb_pixel_row_sensor.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pixel_sensor_pkg.sv
// Shared parameters, types and saturating arithmetic for the pixel row sensor.
package pixel_sensor_pkg;

  localparam int PIXEL_ARRAY_WIDTH = 8;
  localparam int PIXEL_BITS        = 8;

  typedef logic [PIXEL_BITS-1:0] pixel_code_t;
  typedef pixel_code_t [PIXEL_ARRAY_WIDTH-1:0] row_data_t;

  localparam pixel_code_t CODE_MAX = {PIXEL_BITS{1'b1}};

  function automatic pixel_code_t sat_add(input pixel_code_t a, input pixel_code_t b);
    logic [PIXEL_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[PIXEL_BITS]) begin
      return CODE_MAX;
    end else begin
      return sum[PIXEL_BITS-1:0];
    end
  endfunction

  function automatic pixel_code_t sat_inc(input pixel_code_t a);
    if (a == CODE_MAX) begin
      return a;
    end else begin
      return a + pixel_code_t'(1);
    end
  endfunction

endpackage

// File: rtl/pixel_row_sensor_if.sv
// Control/data bundle between the sensor controller and one pixel row.
interface pixel_row_sensor_if;

  logic                           ANALOG_RAMP;
  logic                           ERASE;
  logic                           EXPOSE;
  logic                           READ;
  pixel_sensor_pkg::pixel_code_t  DIGITAL_RAMP;
  pixel_sensor_pkg::row_data_t    LIGHT;
  pixel_sensor_pkg::row_data_t    DATA_OUT;

  modport master (
    output ANALOG_RAMP, ERASE, EXPOSE, READ, DIGITAL_RAMP, LIGHT,
    input  DATA_OUT
  );

  modport slave (
    input  ANALOG_RAMP, ERASE, EXPOSE, READ, DIGITAL_RAMP, LIGHT,
    output DATA_OUT
  );

endinterface

// File: rtl/pixel_cell.sv
// One pixel: saturating light integrator plus single-slope ADC latch.
module pixel_cell
  import pixel_sensor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        erase_i,
  input  logic        expose_i,
  input  logic        convert_i,
  input  pixel_code_t ramp_i,
  input  pixel_code_t digital_ramp_i,
  input  pixel_code_t light_i,
  output pixel_code_t code_o
);

  pixel_code_t level_q, level_d;
  pixel_code_t code_q, code_d;
  logic        done_q, done_d;

  // Next-state: erase beats expose beats convert; a pixel latches once per window.
  always_comb begin
    level_d = level_q;
    code_d  = code_q;
    done_d  = done_q;
    if (erase_i) begin
      level_d = '0;
      code_d  = '0;
      done_d  = 1'b0;
    end else if (expose_i) begin
      level_d = sat_add(level_q, light_i);
    end else if (convert_i && !done_q && (ramp_i >= level_q)) begin
      code_d  = digital_ramp_i;
      done_d  = 1'b1;
    end else begin
      level_d = level_q;
    end
  end

  // Pixel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign code_o = code_q;

endmodule

// File: rtl/pixel_row_sensor.sv
// One row of pixels sharing an analog ramp; readout mux on DATA_OUT.
// Define PIXEL_ROW_TRISTATE_EN to float DATA_OUT while READ is low (shared column bus).
module pixel_row_sensor
  import pixel_sensor_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  pixel_row_sensor_if.slave  bus
);

  pixel_code_t ramp_q, ramp_d;
  logic        active_q, active_d;
  logic        convert_s;
  row_data_t   row_code_s;

  assign convert_s = bus.ANALOG_RAMP & ~bus.ERASE & ~bus.EXPOSE;

  // Shared ramp: cleared by erase/expose, steps while converting, held between windows.
  always_comb begin
    ramp_d   = ramp_q;
    active_d = active_q;
    if (bus.ERASE || bus.EXPOSE) begin
      ramp_d   = '0;
      active_d = 1'b0;
    end else if (convert_s) begin
      ramp_d   = sat_inc(ramp_q);
      active_d = 1'b1;
    end else if (active_q) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end
  end

  // Shared ramp registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_q   <= '0;
      active_q <= 1'b0;
    end else begin
      ramp_q   <= ramp_d;
      active_q <= active_d;
    end
  end

  for (genvar i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin : g_pixel
    pixel_cell u_cell (
      .clk            (clk),
      .reset          (reset),
      .erase_i        (bus.ERASE),
      .expose_i       (bus.EXPOSE),
      .convert_i      (convert_s),
      .ramp_i         (ramp_q),
      .digital_ramp_i (bus.DIGITAL_RAMP),
      .light_i        (bus.LIGHT[i]),
      .code_o         (row_code_s[i])
    );
  end

`ifdef PIXEL_ROW_TRISTATE_EN
  assign bus.DATA_OUT = bus.READ ? row_code_s : 'z;
`else
  assign bus.DATA_OUT = bus.READ ? row_code_s : '0;
`endif

endmodule

// File: tb/tb_pixel_row_sensor.sv
// Directed self-checking bench for pixel_row_sensor.
module tb_pixel_row_sensor;
  import pixel_sensor_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  // Vectors are written pixel 7 down to pixel 0.
  row_data_t light_full = {8'd26, 8'd25, 8'd12, 8'd10, 8'd7, 8'd4, 8'd2, 8'd0};
  row_data_t exp_full   = {8'd255, 8'd250, 8'd120, 8'd100, 8'd70, 8'd40, 8'd20, 8'd0};

  always #5 clk = ~clk;

  pixel_row_sensor_if bus();

  pixel_row_sensor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic do_erase(input int n);
    bus.ERASE = 1'b1;
    repeat (n) @(negedge clk);
    bus.ERASE = 1'b0;
  endtask

  task automatic do_expose(input int n, input row_data_t light);
    bus.LIGHT  = light;
    bus.EXPOSE = 1'b1;
    repeat (n) @(negedge clk);
    bus.EXPOSE = 1'b0;
  endtask

  task automatic do_convert(input int n, input int dstart);
    for (int k = 0; k < n; k++) begin
      bus.DIGITAL_RAMP = pixel_code_t'(dstart + k);
      bus.ANALOG_RAMP  = 1'b1;
      @(negedge clk);
    end
    bus.ANALOG_RAMP = 1'b0;
  endtask

  task automatic read_row(output row_data_t d);
    bus.READ = 1'b1;
    #1;
    d = bus.DATA_OUT;
    bus.READ = 1'b0;
  endtask

  task automatic test_reset;
    row_data_t d;
    reset    = 1'b1;
    bus.READ = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
      checks++;
      if (bus.DATA_OUT[i] !== 8'd0) $display("FAIL reset_read pix%0d got %h want 00", i, bus.DATA_OUT[i]);
      else passes++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    read_row(d);
    checks++;
    if (d !== row_data_t'(0)) $display("FAIL idle_read got %h want 0", d);
    else passes++;
    #1;
    checks++;
`ifdef PIXEL_ROW_TRISTATE_EN
    if (bus.DATA_OUT !== {(PIXEL_ARRAY_WIDTH*PIXEL_BITS){1'bz}}) $display("FAIL noread_z got %h want z", bus.DATA_OUT);
    else passes++;
`else
    if (bus.DATA_OUT !== row_data_t'(0)) $display("FAIL noread_zero got %h want 0", bus.DATA_OUT);
    else passes++;
`endif
    @(negedge clk);
  endtask

  task automatic test_full_sequence(input string tag);
    row_data_t d;
    do_erase(5);
    do_expose(10, light_full);
    do_convert(256, 0);
    read_row(d);
    for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
      checks++;
      if (d[i] !== exp_full[i]) $display("FAIL %s pix%0d got %0d want %0d", tag, i, d[i], exp_full[i]);
      else passes++;
    end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    row_data_t d;
    row_data_t light = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0};
    do_erase(1);
    do_expose(5, light);
    do_convert(256, 0);
    read_row(d);
    checks++;
    if (d !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0}) $display("FAIL sat_255 got %h", d);
    else passes++;
    @(negedge clk);
    do_erase(1);
    do_expose(1, light);
    do_convert(256, 0);
    read_row(d);
    checks++;
    if (d !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0}) $display("FAIL sat_200 got %h", d);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_short_window;
    row_data_t d;
    row_data_t light = {8'd200, 8'd10, 8'd48, 8'd50, 8'd30, 8'd0, 8'd49, 8'd100};
    row_data_t exp1  = {8'd0, 8'd10, 8'd48, 8'd0, 8'd30, 8'd0, 8'd49, 8'd0};
    row_data_t exp2  = {8'd0, 8'd10, 8'd48, 8'd100, 8'd30, 8'd0, 8'd49, 8'd150};
    do_erase(1);
    do_expose(1, light);
    do_convert(50, 0);
    read_row(d);
    for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
      checks++;
      if (d[i] !== exp1[i]) $display("FAIL short_win pix%0d got %0d want %0d", i, d[i], exp1[i]);
      else passes++;
    end
    @(negedge clk);
    // Second window resumes from ramp 50 with digital codes starting at 100.
    do_convert(60, 100);
    read_row(d);
    for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
      checks++;
      if (d[i] !== exp2[i]) $display("FAIL resume_win pix%0d got %0d want %0d", i, d[i], exp2[i]);
      else passes++;
    end
    @(negedge clk);
  endtask

  task automatic test_erase_no_residue;
    row_data_t d;
    test_full_sequence("pre_erase");
    do_erase(1);
    read_row(d);
    checks++;
    if (d !== row_data_t'(0)) $display("FAIL erase_clear got %h want 0", d);
    else passes++;
    @(negedge clk);
    test_full_sequence("repeat");
  endtask

  task automatic test_reset_mid_convert;
    row_data_t d;
    do_erase(5);
    do_expose(10, light_full);
    do_convert(30, 0);
    read_row(d);
    checks++;
    if (d[1] !== 8'd20) $display("FAIL mid_conv_pix1 got %0d want 20", d[1]);
    else passes++;
    bus.ANALOG_RAMP = 1'b1;
    bus.READ        = 1'b1;
    reset           = 1'b1;
    #1;
    checks++;
    if (bus.DATA_OUT !== row_data_t'(0)) $display("FAIL mid_reset got %h want 0", bus.DATA_OUT);
    else passes++;
    bus.ANALOG_RAMP = 1'b0;
    bus.READ        = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_full_sequence("post_reset");
  endtask

  initial begin
    reset            = 1'b0;
    bus.ANALOG_RAMP  = 1'b0;
    bus.ERASE        = 1'b0;
    bus.EXPOSE       = 1'b0;
    bus.READ         = 1'b0;
    bus.DIGITAL_RAMP = '0;
    bus.LIGHT        = '0;
    #2;
    test_reset();
    test_full_sequence("full");
    test_saturation();
    test_short_window();
    test_erase_no_residue();
    test_reset_mid_convert();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
